// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB / page-walk memory subsystem.
// Holds the arbiter state encoding and the address/data width defaults
// used by ptw, memory and mem_arbiter.
package tlb_pkg;

  localparam int unsigned TLB_ADDR_W = 32;
  localparam int unsigned TLB_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

endpackage : tlb_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// Picks the first set request scanning upward from ptr_i with wrap-around.
// Ports:
//   req_i  in  N   request vector
//   ptr_i  in  IW  highest-priority index (must be < N)
//   gnt_o  out N   one-hot grant (zero when no request)
//   idx_o  out IW  index of the granted request
//   any_o  out 1   at least one request present
module rr_pick #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Rank each request by its rotated distance from the pointer; the
  // smallest distance wins. Wrap is computed arithmetically (k + N - p)
  // so non-power-of-2 N never aliases through bit truncation.
  always_comb begin
    int unsigned p;
    int unsigned d;
    int unsigned best_d;
    p      = 32'(ptr_i);
    best_d = N;
    idx_o  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      d = (k >= p) ? (k - p) : (k + N - p);
      if (req_i[k] && (d < best_d)) begin
        best_d = d;
        idx_o  = IW'(k);
      end
    end
  end

  assign any_o = |req_i;

  always_comb begin
    gnt_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      gnt_o[k] = any_o && (idx_o == IW'(k));
    end
  end

endmodule : rr_pick

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters
// (port 0 is the PTW). Exactly one transaction is outstanding at a time.
// Ports:
//   clk, rst                  clock, async active-high reset
//   req_valid_i/req_ready_o   per-requester request handshake
//   req_addr_i                packed per-requester addresses
//   resp_valid_o/resp_ready_i per-requester response handshake
//   resp_data_o               shared response data (owner only)
//   mem_req_valid_o/_ready_i  memory request handshake
//   mem_addr_o                registered memory address
//   mem_resp_valid_i/_ready_o memory response handshake
//   mem_data_i                memory response data
//   grant_idx_o               current owner index
module mem_arbiter
  import tlb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  parameter  int unsigned ADDR_W  = TLB_ADDR_W,
  parameter  int unsigned DATA_W  = TLB_DATA_W,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        resp_valid_o,
  input  logic [NUM_REQ-1:0]        resp_ready_i,
  output logic [DATA_W-1:0]         resp_data_o,
  output logic                      mem_req_valid_o,
  input  logic                      mem_req_ready_i,
  output logic [ADDR_W-1:0]         mem_addr_o,
  input  logic                      mem_resp_valid_i,
  output logic                      mem_resp_ready_o,
  input  logic [DATA_W-1:0]         mem_data_i,
  output logic [IDX_W-1:0]          grant_idx_o
);

  arb_state_e         state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [ADDR_W-1:0]  addr_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [ADDR_W-1:0]  win_addr;
  logic [NUM_REQ-1:0] owner_oh;
  logic               owner_resp_ready;
  logic [IDX_W-1:0]   ptr_next;
  logic               is_idle;
  logic               is_resp;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Address of the current winner.
  always_comb begin
    win_addr = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick_gnt[k]) win_addr = req_addr_i[k*ADDR_W +: ADDR_W];
    end
  end

  // One-hot of the latched owner, used to steer the response channel.
  always_comb begin
    owner_oh = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      owner_oh[k] = (owner_q == IDX_W'(k));
    end
  end

  assign is_idle          = (state_q == ARB_IDLE);
  assign is_resp          = (state_q == ARB_RESP);
  assign owner_resp_ready = |(resp_ready_i & owner_oh);

  // Owner + 1 with an explicit wrap at NUM_REQ-1.
  assign ptr_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  // Grant is offered only in IDLE and is held off while reset is asserted.
  assign req_ready_o      = (is_idle && !rst) ? pick_gnt : '0;
  assign mem_req_valid_o  = (state_q == ARB_ISSUE);
  assign mem_addr_o       = addr_q;
  assign grant_idx_o      = owner_q;

  // Zero-latency response pass-through toward the owner only.
  assign resp_valid_o     = (is_resp && mem_resp_valid_i) ? owner_oh : '0;
  assign resp_data_o      = is_resp ? mem_data_i : '0;
  assign mem_resp_ready_o = is_resp && owner_resp_ready;

  // Transaction sequencer: grant, issue, then wait for response completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      addr_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            addr_q  <= win_addr;
            owner_q <= pick_idx;
            state_q <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (mem_req_ready_i) state_q <= ARB_RESP;
        end
        ARB_RESP: begin
          // Pointer moves only on completion, so the served port drops to
          // lowest priority for the next arbitration.
          if (mem_resp_valid_i && owner_resp_ready) begin
            rr_ptr_q <= ptr_next;
            state_q  <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic, all compared every cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_ready_o;
  logic [N*AW-1:0] req_addr_i = '0;
  logic [N-1:0]    resp_valid_o;
  logic [N-1:0]    resp_ready_i = '0;
  logic [DW-1:0]   resp_data_o;
  logic            mem_req_valid_o;
  logic            mem_req_ready_i = 1'b0;
  logic [AW-1:0]   mem_addr_o;
  logic            mem_resp_valid_i = 1'b0;
  logic            mem_resp_ready_o;
  logic [DW-1:0]   mem_data_i = '0;
  logic [1:0]      grant_idx_o;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_addr_i       (req_addr_i),
    .resp_valid_o     (resp_valid_o),
    .resp_ready_i     (resp_ready_i),
    .resp_data_o      (resp_data_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_addr_o       (mem_addr_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_ready_o (mem_resp_ready_o),
    .mem_data_i       (mem_data_i),
    .grant_idx_o      (grant_idx_o)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  bit             m_busy;   // a transaction has been granted
  bit             m_sent;   // its request was accepted by memory
  int             m_owner;
  int             m_ptr;
  logic [AW-1:0]  m_addr;

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (((v >> ((p + i) % N)) & N'(1)) != '0) return (p + i) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_sent <= 1'b0; m_owner <= 0; m_ptr <= 0; m_addr <= '0;
    end else if (!m_busy) begin
      if (winner(req_valid_i, m_ptr) >= 0) begin
        m_busy  <= 1'b1;
        m_sent  <= 1'b0;
        m_owner <= winner(req_valid_i, m_ptr);
        m_addr  <= AW'(req_addr_i >> (winner(req_valid_i, m_ptr) * AW));
      end
    end else if (!m_sent) begin
      if (mem_req_ready_i) m_sent <= 1'b1;
    end else if (mem_resp_valid_i && (((resp_ready_i >> m_owner) & N'(1)) != '0)) begin
      m_busy <= 1'b0;
      m_sent <= 1'b0;
      m_ptr  <= (m_owner + 1) % N;
    end
  end

  function automatic logic [N-1:0] e_req_ready();
    int w;
    w = winner(req_valid_i, m_ptr);
    if (rst || m_busy || w < 0) return '0;
    return N'(1) << w;
  endfunction

  function automatic logic [N-1:0] e_resp_valid();
    return (m_busy && m_sent && mem_resp_valid_i) ? (N'(1) << m_owner) : '0;
  endfunction

  function automatic logic e_mem_resp_ready();
    return m_busy && m_sent && (((resp_ready_i >> m_owner) & N'(1)) != '0);
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (((v >> i) & N'(1)) != '0) return i;
    return -1;
  endfunction

  // Observed handshakes and delivered responses.
  logic [N-1:0]  last_hs = '0;
  int            cq_port[$];
  logic [DW-1:0] cq_data[$];

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    chk("req_ready",      req_ready_o,      e_req_ready());
    chk("mem_req_valid",  mem_req_valid_o,  m_busy && !m_sent);
    chk("mem_addr",       mem_addr_o,       m_addr);
    chk("grant_idx",      grant_idx_o,      64'(m_owner));
    chk("resp_valid",     resp_valid_o,     e_resp_valid());
    chk("mem_resp_ready", mem_resp_ready_o, e_mem_resp_ready());
    chk("resp_data",      resp_data_o,      (m_busy && m_sent) ? mem_data_i : '0);
    last_hs <= req_valid_i & req_ready_o;
    if ((resp_valid_o & resp_ready_i) != '0) begin
      cq_port.push_back(onehot_idx(resp_valid_o & resp_ready_i));
      cq_data.push_back(resp_data_o);
    end
  end

  // ---------------- stimulus ----------------
  bit drop_on_grant = 1'b0;
  bit auto_mem      = 1'b0;

  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
    case (a)
      32'h0000_0400: return 32'h0000_0801;
      32'h0000_0800: return 32'h1000_000F;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic set_addr(input int k, input logic [AW-1:0] a);
    req_addr_i[k*AW +: AW] = a;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (drop_on_grant) req_valid_i = req_valid_i & ~last_hs;
    if (auto_mem) begin
      mem_req_ready_i  = 1'b1;
      mem_resp_valid_i = 1'b1;
      mem_data_i       = memfn(mem_addr_o);
    end
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic run_until(input int n);
    int c;
    c = 0;
    while (cq_port.size() < n && c < 200) begin
      tick();
      c++;
    end
    chk("completion_timeout", 64'(cq_port.size() >= n), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready",     req_ready_o,     '0);
    chk("rst_mem_req_valid", mem_req_valid_o, 1'b0);
    chk("rst_grant",         grant_idx_o,     '0);
    chk("rst_mem_addr",      mem_addr_o,      '0);
    rst = 1'b0;

    // Port 0 alone reads 0x0400.
    auto_mem = 1'b1; drop_on_grant = 1'b1; resp_ready_i = '1;
    set_addr(0, 32'h0400); req_valid_i = 3'b001;
    at_neg();
    chk("p0_ready", req_ready_o, 3'b001);
    tick(); at_neg();
    chk("p0_addr", mem_addr_o, 32'h0400);
    chk("p0_issue", mem_req_valid_o, 1'b1);
    tick(); at_neg();
    chk("p0_resp_valid", resp_valid_o, 3'b001);
    chk("p0_data", resp_data_o, 32'h0000_0801);
    tick(); at_neg();
    chk("p0_idle_resp", resp_valid_o, '0);
    chk("p0_count", cq_port.size(), 1);
    chk("p0_port", cq_port[0], 0);

    // Ports 0 and 1 valid from reset.
    tick(); rst = 1'b1;
    cq_port.delete(); cq_data.delete();
    set_addr(1, 32'h0800); req_valid_i = 3'b011;
    tick(); rst = 1'b0;
    run_until(2);
    req_valid_i = '0;
    chk("dual_first_port",  cq_port[0], 0);
    chk("dual_first_data",  cq_data[0], 32'h0000_0801);
    chk("dual_second_port", cq_port[1], 1);
    chk("dual_second_data", cq_data[1], 32'h1000_000F);

    // Both held valid for 4 transactions: strict alternation.
    cq_port.delete(); cq_data.delete();
    drop_on_grant = 1'b0; req_valid_i = 3'b011;
    run_until(4);
    req_valid_i = '0;
    for (int i = 0; i < 4; i++) begin
      chk("alt_port", cq_port[i], i % 2);
      chk("alt_data", cq_data[i], (i % 2 == 0) ? 32'h0000_0801 : 32'h1000_000F);
    end

    // Port 1 stalls its response for 5 cycles.
    cq_port.delete(); cq_data.delete();
    drop_on_grant = 1'b1; resp_ready_i = 3'b101; req_valid_i = 3'b010;
    for (int c = 0; c < 20; c++) begin
      tick(); at_neg();
      if (resp_valid_o[1]) break;
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_mrr",    mem_resp_ready_o, 1'b0);
      chk("hold_data",   resp_data_o, 32'h1000_000F);
      chk("hold_valid",  resp_valid_o, 3'b010);
      chk("hold_nocomp", cq_port.size(), 0);
      tick();
      if (i < 4) at_neg();
    end
    resp_ready_i = '1;
    at_neg();
    chk("hold_release_mrr", mem_resp_ready_o, 1'b1);
    chk("hold_release_cnt", cq_port.size(), 1);
    tick(); at_neg();
    chk("hold_idle_issue", mem_req_valid_o, 1'b0);
    chk("hold_idle_resp",  resp_valid_o, '0);

    // Spurious memory response in IDLE.
    auto_mem = 1'b0; mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1;
    mem_data_i = 32'hDEAD_BEEF; req_valid_i = '0;
    cq_port.delete(); cq_data.delete();
    for (int i = 0; i < 3; i++) begin
      tick(); at_neg();
      chk("spur_resp_valid", resp_valid_o, '0);
      chk("spur_mrr",        mem_resp_ready_o, 1'b0);
      chk("spur_data",       resp_data_o, '0);
      chk("spur_issue",      mem_req_valid_o, 1'b0);
    end

    // ISSUE stall with a competing request from port 0.
    tick();
    mem_resp_valid_i = 1'b0; set_addr(2, 32'h1234); req_valid_i = 3'b100;
    tick();
    set_addr(0, 32'h4444); req_valid_i = req_valid_i | 3'b001;
    for (int i = 0; i < 10; i++) begin
      at_neg();
      chk("stall_addr",  mem_addr_o, 32'h1234);
      chk("stall_grant", grant_idx_o, 2'd2);
      chk("stall_issue", mem_req_valid_o, 1'b1);
      chk("stall_ready", req_ready_o, '0);
      tick();
    end
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_data_i = 32'hCAFE_F00D;
    at_neg();
    chk("stall_resp_valid", resp_valid_o, 3'b100);
    chk("stall_resp_data",  resp_data_o, 32'hCAFE_F00D);
    tick();
    chk("stall_cnt",  cq_port.size(), 1);
    chk("stall_port", cq_port[0], 2);

    // Asynchronous reset during RESP.
    rst = 1'b1; req_valid_i = '0; mem_resp_valid_i = 1'b0;
    tick(); rst = 1'b0;
    cq_port.delete(); cq_data.delete();
    set_addr(0, 32'h0400); req_valid_i = 3'b001; mem_req_ready_i = 1'b1;
    tick(); tick();
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_data_i = 32'h0000_0801;
    #2;
    chk("arst_pre_valid", resp_valid_o, 3'b001);
    #1 rst = 1'b1;
    #1;
    chk("arst_resp_valid", resp_valid_o, '0);
    chk("arst_issue",      mem_req_valid_o, 1'b0);
    chk("arst_grant",      grant_idx_o, '0);
    chk("arst_addr",       mem_addr_o, '0);
    chk("arst_mrr",        mem_resp_ready_o, 1'b0);
    tick(); rst = 1'b0; mem_resp_valid_i = 1'b0;
    chk("arst_nocomp", cq_port.size(), 0);

    // Randomized traffic against the model.
    drop_on_grant = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) req_valid_i[k] = ~req_valid_i[k];
        if ($urandom_range(0, 7) == 0) set_addr(k, $urandom);
      end
      mem_req_ready_i  = ($urandom_range(0, 2) != 0);
      mem_resp_valid_i = ($urandom_range(0, 1) != 0);
      mem_data_i       = $urandom;
      resp_ready_i     = N'($urandom);
    end
    tick(); rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mem_arbiter
